// File: rtl/hc_gate_if.sv
// Bundle of gate inputs, mode-change handshake and filtered outputs for hc_gate_array.
// The master drives the gate inputs and mode requests; the slave (the gate array) returns the outputs.
interface hc_gate_if #(
    parameter int CH = 4
);
    logic [CH-1:0] a;
    logic [CH-1:0] b;
    logic          cfg_valid;
    logic [1:0]    cfg_mode;
    logic          cfg_ready;
    logic [CH-1:0] y;
    logic [CH-1:0] chg;

    modport master (
        output a, b, cfg_valid, cfg_mode,
        input  cfg_ready, y, chg
    );

    modport slave (
        input  a, b, cfg_valid, cfg_mode,
        output cfg_ready, y, chg
    );
endinterface

// File: rtl/hc_gate_array.sv
// hc_gate_array: CH independent 2-input gates (AND/OR/XOR/NAND, run-time selectable)
// with a per-channel deglitch filter. An output moves only after its gate result has
// disagreed with it for FILT consecutive cycles. A mode change freezes the outputs
// for FILT cycles (HOLD) so the new function starts from a clean filter state.
// Optional feature macro: HC_GATE_SYNC_EN adds a 2-flop synchroniser on every A/B bit.
module hc_gate_array #(
    parameter int CH   = 4,
    parameter int FILT = 3
) (
    input logic    clk,
    input logic    rst_n,
    hc_gate_if.slave bus
);
    localparam int            CW       = $clog2(FILT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [1:0]    mode_reg, mode_next;
    logic          ready_reg, ready_next;
    logic          accept;
    logic          filt_en;

    logic [CH-1:0] a_q_reg, b_q_reg;
    logic [CH-1:0] g;
    logic [CH-1:0] y_vec, chg_vec;

`ifdef HC_GATE_SYNC_EN
    logic [CH-1:0] a_s1_reg, a_s2_reg, b_s1_reg, b_s2_reg;

    // Two-flop synchronisers, then the sampling register feeding the gates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_reg <= '0;
            a_s2_reg <= '0;
            b_s1_reg <= '0;
            b_s2_reg <= '0;
            a_q_reg  <= '0;
            b_q_reg  <= '0;
        end else begin
            a_s1_reg <= bus.a;
            a_s2_reg <= a_s1_reg;
            b_s1_reg <= bus.b;
            b_s2_reg <= b_s1_reg;
            a_q_reg  <= a_s2_reg;
            b_q_reg  <= b_s2_reg;
        end
    end
`else
    // Inputs are already clk-synchronous: sample them directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q_reg <= '0;
            b_q_reg <= '0;
        end else begin
            a_q_reg <= bus.a;
            b_q_reg <= bus.b;
        end
    end
`endif

    // Gate function applied to all channels from registered inputs.
    always_comb begin
        g = a_q_reg & b_q_reg;
        case (mode_reg)
            2'b00:   g = a_q_reg & b_q_reg;
            2'b01:   g = a_q_reg | b_q_reg;
            2'b10:   g = a_q_reg ^ b_q_reg;
            default: g = ~(a_q_reg & b_q_reg);
        endcase
    end

    // Mode FSM state, hold counter, mode and registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            mode_reg     <= 2'b00;
            ready_reg    <= 1'b1;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            mode_reg     <= mode_next;
            ready_reg    <= ready_next;
        end
    end

    // Next-state logic: accept a mode in IDLE, then hold for exactly FILT cycles.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        mode_next     = mode_reg;
        accept        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.cfg_valid && ready_reg) begin
                    accept        = 1'b1;
                    mode_next     = bus.cfg_mode;
                    hold_cnt_next = '0;
                    state_next    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_reg == CNT_LAST) begin
                    hold_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        ready_next = (state_next == IDLE);
        // An accept on this edge discards any commit the filters would make.
        filt_en    = (state_reg == IDLE) && !accept;
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [CW-1:0] cnt_reg;
            logic          y_bit_reg;
            logic          chg_bit_reg;

            // Deglitch filter: commit g to Y after FILT consecutive mismatching cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg     <= '0;
                    y_bit_reg   <= 1'b0;
                    chg_bit_reg <= 1'b0;
                end else if (!filt_en || (g[gi] == y_bit_reg)) begin
                    cnt_reg     <= '0;
                    chg_bit_reg <= 1'b0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_reg     <= '0;
                    y_bit_reg   <= g[gi];
                    chg_bit_reg <= 1'b1;
                end else begin
                    cnt_reg     <= cnt_reg + CW'(1);
                    chg_bit_reg <= 1'b0;
                end
            end

            assign y_vec[gi]   = y_bit_reg;
            assign chg_vec[gi] = chg_bit_reg;
        end
    endgenerate

    assign bus.y         = y_vec;
    assign bus.chg       = chg_vec;
    assign bus.cfg_ready = ready_reg;
endmodule
